// File: rtl/maxpool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_pkg
// Brief    : State encoding, default geometry/counter widths and the signed
//            max helper shared by the 2x2 max-pool stage.
// Revision : 1.0  initial release
// ============================================================================
package maxpool_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_RUN  = 2'd1;
    localparam state_t c_DONE = 2'd2;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_IMG_W      = 8;
    localparam int c_DEF_IMG_H      = 8;
    localparam int c_DEF_COL_W      = $clog2(c_DEF_IMG_W);
    localparam int c_DEF_ROW_W      = $clog2(c_DEF_IMG_H);
    localparam int c_DEF_OUT_W      = $clog2(c_DEF_IMG_W / 2 * c_DEF_IMG_H / 2 + 1);

    // Operands are sign-extended to 32 bits by the caller, so any pixel width up to 32 works.
    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool2x2_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2x2_linebuf
// Brief    : One-row buffer of horizontal pair maxima; one write port and one
//            asynchronous read port sharing a single address.
// Revision : 1.0  initial release
// ============================================================================
module maxpool2x2_linebuf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2x2
// Brief    : Streaming 2x2 / stride-2 signed max-pool with start/done framing.
//            Define MAXPOOL_RELU_EN to clamp negative pooled values to zero.
// Revision : 1.0  initial release
// ============================================================================
module maxpool2x2
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int IMG_W      = c_DEF_IMG_W,
    parameter int IMG_H      = c_DEF_IMG_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int c_COL_W  = $clog2(IMG_W);
    localparam int c_ROW_W  = $clog2(IMG_H);
    localparam int c_NOUT   = (IMG_W / 2) * (IMG_H / 2);
    localparam int c_OUT_W  = $clog2(c_NOUT + 1);
    localparam int c_ADDR_W = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

    state_t                       state_q, state_d;
    logic [c_COL_W-1:0]           col_q, col_d;
    logic [c_ROW_W-1:0]           row_q, row_d;
    logic [c_OUT_W-1:0]           out_cnt_q, out_cnt_d;
    logic signed [DATA_WIDTH-1:0] h_max_q, h_max_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;

    logic                         w_accept, w_out_hs, w_last_col, w_last_row;
    logic                         w_lb_we, w_win_done;
    logic [c_ADDR_W-1:0]          w_lb_addr;
    logic signed [DATA_WIDTH-1:0] w_din, w_hp, w_lb_rd, w_pooled, w_result;

    assign w_din        = data_in;
    assign in_ready_out = (state_q == c_RUN) && (!out_valid_q || out_ready_in);
    assign w_accept     = in_valid_in && in_ready_out;
    assign w_out_hs     = out_valid_q && out_ready_in;
    assign w_last_col   = (col_q == c_COL_W'(IMG_W - 1));
    assign w_last_row   = (row_q == c_ROW_W'(IMG_H - 1));

    // Even rows park the horizontal pair max; odd rows combine it with the row above.
    assign w_hp       = DATA_WIDTH'(smax(32'(h_max_q), 32'(w_din)));
    assign w_lb_addr  = c_ADDR_W'(col_q >> 1);
    assign w_lb_we    = w_accept && !row_q[0] && col_q[0];
    assign w_win_done = w_accept &&  row_q[0] && col_q[0];
    assign w_pooled   = DATA_WIDTH'(smax(32'(w_lb_rd), 32'(w_hp)));

`ifdef MAXPOOL_RELU_EN
    assign w_result = w_pooled[DATA_WIDTH-1] ? '0 : w_pooled;
`else
    assign w_result = w_pooled;
`endif

    maxpool2x2_linebuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W / 2),
        .ADDR_W     (c_ADDR_W)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (w_lb_we),
        .addr_i  (w_lb_addr),
        .wdata_i (w_hp),
        .rdata_o (w_lb_rd)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        out_cnt_d   = out_cnt_q;
        h_max_d     = h_max_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (w_accept) begin
            if (w_last_col) begin
                col_d = '0;
                row_d = w_last_row ? '0 : row_q + c_ROW_W'(1);
            end else begin
                col_d = col_q + c_COL_W'(1);
            end
            if (!col_q[0]) begin
                h_max_d = w_din;
            end
        end

        if (w_out_hs) begin
            out_cnt_d = out_cnt_q + c_OUT_W'(1);
        end

        // A fresh result wins over a same-cycle handshake, keeping the stream bubble-free.
        if (w_win_done) begin
            out_valid_d = 1'b1;
            out_data_d  = w_result;
        end else if (w_out_hs) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d   = c_RUN;
                    col_d     = '0;
                    row_d     = '0;
                    out_cnt_d = '0;
                end
            end
            c_RUN: begin
                if (w_out_hs && (out_cnt_q == c_OUT_W'(c_NOUT - 1))) begin
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_cnt_q   <= '0;
            h_max_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_cnt_q   <= out_cnt_d;
            h_max_q     <= h_max_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign done          = (state_q == c_DONE);
    assign out_valid_out = out_valid_q;
    assign out_data      = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool2x2
// Brief    : Directed checks of the 2x2 max-pool on a 4x4 and an 8x6 instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_maxpool2x2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_start, a_done, a_valid, a_ready, a_ovalid, a_oready;
    logic [7:0] a_din, a_odata;
    logic       b_start, b_done, b_valid, b_ready, b_ovalid, b_oready;
    logic [7:0] b_din, b_odata;

    maxpool2x2 #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .done(a_done),
        .in_valid_in(a_valid), .in_ready_out(a_ready), .data_in(a_din),
        .out_valid_out(a_ovalid), .out_ready_in(a_oready), .out_data(a_odata)
    );

    maxpool2x2 #(.DATA_WIDTH(8), .IMG_W(8), .IMG_H(6)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .done(b_done),
        .in_valid_in(b_valid), .in_ready_out(b_ready), .data_in(b_din),
        .out_valid_out(b_ovalid), .out_ready_in(b_oready), .out_data(b_odata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0]        pix_a [16];
    logic signed [7:0] pix_b [48];
    int                lat_idx [4] = '{5, 7, 13, 15};

    // Observation side: append-only records taken half a cycle before each edge.
    int         cyc = 0;
    logic [7:0] a_outs [$];
    int         a_hs_cyc [$];
    int         a_acc_cyc [$];
    int         a_rise_cyc [$];
    int         a_done_cnt = 0;
    int         a_done_cyc = -1;
    logic       a_ov_prev = 1'b0;
    logic [7:0] b_outs [$];
    int         b_done_cnt = 0;
    int         b_viol = 0;
    logic       b_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_ovalid && a_oready) begin
            a_outs.push_back(a_odata);
            a_hs_cyc.push_back(cyc + 1);
        end
        if (a_valid && a_ready) a_acc_cyc.push_back(cyc + 1);
        if (a_ovalid && !a_ov_prev) a_rise_cyc.push_back(cyc);
        a_ov_prev <= a_ovalid;
        if (a_done) begin
            a_done_cnt <= a_done_cnt + 1;
            a_done_cyc <= cyc;
        end
        if (b_ovalid && b_oready) b_outs.push_back(b_odata);
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (b_ready && !b_run) b_viol <= b_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d, input logic st);
        int g;
        g       = 0;
        a_din   = d;
        a_valid = 1'b1;
        a_start = st;
        @(negedge clk);
        while (!a_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!a_ready) chk("a_accept_timeout", a_ready, 1);
        tick();
        a_valid = 1'b0;
        a_start = 1'b0;
    endtask

    task automatic send_frame_a(input int mid_start);
        for (int i = 0; i < 16; i++) send_a(pix_a[i], i == mid_start);
    endtask

    task automatic wait_done_a();
        int g;
        g = 0;
        while (!a_done && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!a_done) chk("a_done_timeout", a_done, 1);
        tick();
    endtask

    task automatic check_frame_a(input string tag, input int ob, input int db,
                                 input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, 32'(a_outs.size() - ob), 4);
        for (int k = 0; k < 4; k++)
            chk({tag, "_value"}, (ob + k < a_outs.size()) ? 32'(a_outs[ob + k]) : 32'hDEAD,
                32'(e[k]));
        chk({tag, "_done_count"}, 32'(a_done_cnt - db), 1);
        if (a_hs_cyc.size() > 0)
            chk({tag, "_done_timing"}, 32'(a_done_cyc), 32'(a_hs_cyc[a_hs_cyc.size() - 1]));
    endtask

    task automatic send_b(input logic [7:0] d);
        int g;
        g       = 0;
        b_din   = d;
        b_valid = 1'b1;
        @(negedge clk);
        while (!b_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!b_ready) chk("b_accept_timeout", b_ready, 1);
        tick();
        b_valid = 1'b0;
    endtask

    function automatic logic [7:0] exp_b(input int k);
        int                base;
        logic signed [7:0] m;
        base = 2 * (k / 4) * 8 + 2 * (k % 4);
        m    = pix_b[base];
        if (pix_b[base + 1] > m) m = pix_b[base + 1];
        if (pix_b[base + 8] > m) m = pix_b[base + 8];
        if (pix_b[base + 9] > m) m = pix_b[base + 9];
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 8'sd0;
`endif
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, db, ab, rb, bb, bd;
        rst = 1'b1;
        a_start = 0; a_valid = 1; a_din = 8'h55; a_oready = 1;
        b_start = 0; b_valid = 0; b_din = 0;     b_oready = 1;

        // Reset state, then IDLE must refuse a pending pixel.
        repeat (3) tick();
        chk("rst_out_valid", a_ovalid, 0);
        chk("rst_out_data",  a_odata,  0);
        chk("rst_done",      a_done,   0);
        chk("rst_in_ready",  a_ready,  0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_in_ready",  a_ready, 0);
        chk("idle_no_accept", 32'(a_acc_cyc.size()), 0);
        a_valid = 0;

        // 1: ramp frame, continuous flow, latency of each window result.
        for (int i = 0; i < 16; i++) pix_a[i] = 8'(i);
        ob = a_outs.size(); db = a_done_cnt; ab = a_acc_cyc.size(); rb = a_rise_cyc.size();
        start_a();
        send_frame_a(-1);
        wait_done_a();
        check_frame_a("s1", ob, db, 8'd5, 8'd7, 8'd13, 8'd15);
        for (int k = 0; k < 4; k++)
            chk("s1_latency",
                (rb + k < a_rise_cyc.size()) ? 32'(a_rise_cyc[rb + k]) : 32'hDEAD,
                (ab + lat_idx[k] < a_acc_cyc.size()) ? 32'(a_acc_cyc[ab + lat_idx[k]]) : 32'hBEEF);

        // 2: downstream stall for 5 cycles on the first result.
        ob = a_outs.size(); db = a_done_cnt;
        a_oready = 1'b0;
        start_a();
        fork
            send_frame_a(-1);
            begin
                int g;
                g = 0;
                @(negedge clk);
                while (!a_ovalid && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                if (!a_ovalid) chk("s2_valid_timeout", a_ovalid, 1);
                for (int k = 0; k < 5; k++) begin
                    chk("s2_hold_data",     a_odata,  8'd5);
                    chk("s2_hold_valid",    a_ovalid, 1);
                    chk("s2_stall_in_ready", a_ready, 0);
                    if (k < 4) @(negedge clk);
                end
                tick();
                a_oready = 1'b1;
            end
        join
        wait_done_a();
        check_frame_a("s2", ob, db, 8'd5, 8'd7, 8'd13, 8'd15);

        // 3: negative values, signed compare and optional clamp.
        for (int i = 0; i < 16; i++) pix_a[i] = 8'h80;
        pix_a[0] = 8'hFD; pix_a[1] = 8'hFF; pix_a[4] = 8'hF8; pix_a[5] = 8'hFE;
        ob = a_outs.size(); db = a_done_cnt;
        start_a();
        send_frame_a(-1);
        wait_done_a();
`ifdef MAXPOOL_RELU_EN
        check_frame_a("s3", ob, db, 8'h00, 8'h00, 8'h00, 8'h00);
`else
        check_frame_a("s3", ob, db, 8'hFF, 8'h80, 8'h80, 8'h80);
`endif

        // 4: start re-asserted mid-frame is ignored.
        for (int i = 0; i < 16; i++) pix_a[i] = 8'(i);
        ob = a_outs.size(); db = a_done_cnt;
        start_a();
        send_frame_a(8);
        wait_done_a();
        check_frame_a("s4", ob, db, 8'd5, 8'd7, 8'd13, 8'd15);

        // 5: asynchronous reset mid-frame with a result pending.
        a_oready = 1'b0;
        start_a();
        for (int i = 0; i < 6; i++) send_a(pix_a[i], 1'b0);
        chk("s5_pre_valid", a_ovalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_out_valid", a_ovalid, 0);
        chk("s5_rst_done",      a_done,   0);
        chk("s5_rst_out_data",  a_odata,  0);
        chk("s5_rst_in_ready",  a_ready,  0);
        tick();
        rst = 1'b0;
        a_oready = 1'b1;
        tick();
        ob = a_outs.size(); db = a_done_cnt;
        start_a();
        send_frame_a(-1);
        wait_done_a();
        check_frame_a("s5", ob, db, 8'd5, 8'd7, 8'd13, 8'd15);

        // 6: 8x6 frame with random gaps on both sides.
        for (int i = 0; i < 48; i++) pix_b[i] = 8'($urandom_range(0, 255));
        pix_b[0] = 8'h80; pix_b[1] = 8'h80; pix_b[8] = 8'h80; pix_b[9] = 8'h80;
        pix_b[4] = 8'h11; pix_b[5] = 8'h11; pix_b[12] = 8'h11; pix_b[13] = 8'h11;
        pix_b[2] = 8'h7F;
        bb = b_outs.size(); bd = b_done_cnt;
        b_valid = 1'b1;
        repeat (3) tick();
        b_valid = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_run   = 1'b1;
        fork
            for (int i = 0; i < 48; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_b(pix_b[i]);
            end
            for (int k = 0; k < 3000 && b_done_cnt == bd; k++) begin
                b_oready = 1'($urandom_range(0, 1));
                tick();
            end
        join
        tick();
        b_run    = 1'b0;
        b_oready = 1'b1;
        repeat (3) tick();
        chk("s6_count", 32'(b_outs.size() - bb), 12);
        for (int k = 0; k < 12; k++)
            chk("s6_value", (bb + k < b_outs.size()) ? 32'(b_outs[bb + k]) : 32'hDEAD,
                32'(exp_b(k)));
        chk("s6_done_count", 32'(b_done_cnt - bd), 1);
        chk("s6_ready_outside_run", 32'(b_viol), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
